// File: rtl/nios2_oci_trace_pkg.sv
// Shared constants and lane-address helper for the OCI trace FIFO controller.
// Pure declarations: no latency, no flow control of its own.
package nios2_oci_trace_pkg;

  localparam int unsigned TRACE_DEPTH = 16;
  localparam int unsigned TRACE_PTR_W = 4;
  localparam int unsigned TM_CNT_W    = 2;

  // DEPTH is a power of two, so the wrap is a mask.
  function automatic logic [31:0] lane_addr(
    input logic [31:0]         base,
    input logic [TM_CNT_W-1:0] lane,
    input int unsigned         depth
  );
    return (base + 32'(lane)) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/nios2_oci_fifo_status.sv
// Combinational decode of the registered occupancy into status flags and free space.
// Latency 0; no backpressure, pure decode.
module nios2_oci_fifo_status
  import nios2_oci_trace_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH,
  parameter int unsigned PTR_W = TRACE_PTR_W
) (
  input  logic [PTR_W:0] fifocount,
  output logic           empty,
  output logic           full,
  output logic           free2,
  output logic           free3,
  output logic [PTR_W:0] free
);

  localparam int unsigned CNT_W = PTR_W + 1;

  assign empty = (fifocount == '0);
  assign full  = (fifocount == CNT_W'(DEPTH));
  assign free2 = (fifocount <= CNT_W'(DEPTH - 2));
  assign free3 = (fifocount <= CNT_W'(DEPTH - 3));
  assign free  = CNT_W'(DEPTH) - fifocount;

endmodule

// File: rtl/nios2_oci_fifo_ctrl.sv
// Pointer/occupancy/admission control for the OCI trace FIFO; state updates 1 cycle after the request.
// Backpressure: a group that does not fit in registered free space is dropped whole and counted.
module nios2_oci_fifo_ctrl
  import nios2_oci_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = TRACE_DEPTH,
  parameter int unsigned PTR_W  = TRACE_PTR_W,
  parameter int unsigned DROP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [TM_CNT_W-1:0] tm_count,
  input  logic                rd_req,
  input  logic                flush,
  input  logic                ovf_clr,
  output logic [2:0]          wr_en,
  output logic [PTR_W-1:0]    wr_addr0,
  output logic [PTR_W-1:0]    wr_addr1,
  output logic [PTR_W-1:0]    wr_addr2,
  output logic [PTR_W-1:0]    rd_addr,
  output logic                rd_valid,
  output logic [PTR_W:0]      fifocount,
  output logic                empty,
  output logic                full,
  output logic                free2,
  output logic                free3,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  rp_q, rp_d;
  logic [CNT_W-1:0]  fifocount_q, fifocount_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  logic [CNT_W-1:0]  free;
  logic              offer;
  logic              accept;
  logic              drop;
  logic              pop;
  logic [PTR_W-1:0]  wr_num;

  nios2_oci_fifo_status #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_status (
    .fifocount (fifocount_q),
    .empty     (empty),
    .full      (full),
    .free2     (free2),
    .free3     (free3),
    .free      (free)
  );

  // Free space ignores a same-cycle pop, so admission never relies on the consumer.
  always_comb begin
    offer  = enable && (tm_count != '0);
    accept = offer && !flush && (CNT_W'(tm_count) <= free);
    drop   = offer && !flush && !accept;
    pop    = rd_req && !empty && !flush;
    wr_num = accept ? PTR_W'(tm_count) : '0;
  end

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < 3; i++) begin
      wr_en[i] = accept && (tm_count > TM_CNT_W'(i));
    end
  end

  assign wr_addr0 = wp_q;
  assign wr_addr1 = PTR_W'(lane_addr(32'(wp_q), 2'd1, DEPTH));
  assign wr_addr2 = PTR_W'(lane_addr(32'(wp_q), 2'd2, DEPTH));
  assign rd_addr  = rp_q;
  assign rd_valid = pop;

  always_comb begin
    wp_d         = wp_q;
    rp_d         = rp_q;
    fifocount_d  = fifocount_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (flush) begin
      wp_d        = '0;
      rp_d        = '0;
      fifocount_d = '0;
    end else begin
      wp_d        = wp_q + wr_num;
      rp_d        = rp_q + PTR_W'(pop);
      fifocount_d = fifocount_q + CNT_W'(wr_num) - CNT_W'(pop);
    end

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clr) begin
        drop_count_d = DROP_W'(1);
      end else if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + 1'b1;
      end
    end else if (ovf_clr) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q         <= '0;
      rp_q         <= '0;
      fifocount_q  <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      fifocount_q  <= fifocount_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign fifocount  = fifocount_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_nios2_oci_fifo_ctrl.sv
// Directed plus random stimulus against an occupancy/pointer model of the trace FIFO controller.
module tb_nios2_oci_fifo_ctrl;

  localparam int D  = 16;
  localparam int PW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, rd_req, flush, ovf_clr;
  logic [1:0]    tm_count;
  logic [2:0]    wr_en;
  logic [PW-1:0] wr_addr0, wr_addr1, wr_addr2, rd_addr;
  logic          rd_valid, empty, full, free2, free3, overflow;
  logic [PW:0]   fifocount;
  logic [DW-1:0] drop_count;

  nios2_oci_fifo_ctrl #(.DEPTH(D), .PTR_W(PW), .DROP_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tm_count   (tm_count),
    .rd_req     (rd_req),
    .flush      (flush),
    .ovf_clr    (ovf_clr),
    .wr_en      (wr_en),
    .wr_addr0   (wr_addr0),
    .wr_addr1   (wr_addr1),
    .wr_addr2   (wr_addr2),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .fifocount  (fifocount),
    .empty      (empty),
    .full       (full),
    .free2      (free2),
    .free3      (free3),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: occupancy and pointers as plain integers.
  int m_wp, m_rp, m_occ, m_drops;
  bit m_ovf;

  // Combinational outputs captured during the most recent step.
  logic [2:0]    c_wr_en;
  logic [PW-1:0] c_a0, c_a1, c_a2, c_rd_addr;
  logic          c_rd_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string ph);
    check({ph, ".fifocount"},  32'(fifocount),  32'(m_occ));
    check({ph, ".empty"},      32'(empty),      32'(m_occ == 0));
    check({ph, ".full"},       32'(full),       32'(m_occ == D));
    check({ph, ".free2"},      32'(free2),      32'(m_occ <= D - 2));
    check({ph, ".free3"},      32'(free3),      32'(m_occ <= D - 3));
    check({ph, ".overflow"},   32'(overflow),   32'(m_ovf));
    check({ph, ".drop_count"}, 32'(drop_count), 32'(m_drops));
    check({ph, ".wp"},         32'(wr_addr0),   32'(m_wp));
    check({ph, ".rp"},         32'(rd_addr),    32'(m_rp));
  endtask

  task automatic do_reset(input bit noisy);
    @(negedge clk);
    reset    = 1'b1;
    enable   = noisy;
    tm_count = noisy ? 2'd3 : 2'd0;
    rd_req   = noisy;
    flush    = noisy;
    ovf_clr  = noisy;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_wp = 0; m_rp = 0; m_occ = 0; m_drops = 0; m_ovf = 1'b0;
    check_state("reset");
  endtask

  task automatic step(input bit en, input int cnt, input bit rd, input bit fl, input bit clr);
    int free;
    bit offer, acc, pop;
    @(negedge clk);
    enable = en; tm_count = 2'(cnt); rd_req = rd; flush = fl; ovf_clr = clr;
    #1;
    free  = D - m_occ;
    offer = en && (cnt != 0);
    acc   = offer && !fl && (cnt <= free);
    pop   = rd && (m_occ != 0) && !fl;
    c_wr_en = wr_en; c_a0 = wr_addr0; c_a1 = wr_addr1; c_a2 = wr_addr2;
    c_rd_addr = rd_addr; c_rd_valid = rd_valid;
    check("wr_en",    32'(wr_en),    acc ? 32'((1 << cnt) - 1) : 32'd0);
    check("wr_addr1", 32'(wr_addr1), 32'((m_wp + 1) % D));
    check("wr_addr2", 32'(wr_addr2), 32'((m_wp + 2) % D));
    check("rd_valid", 32'(rd_valid), 32'(pop));
    if (fl) begin
      m_wp = 0; m_rp = 0; m_occ = 0;
    end else begin
      m_wp  = (m_wp + (acc ? cnt : 0)) % D;
      m_rp  = (m_rp + (pop ? 1 : 0)) % D;
      m_occ = m_occ + (acc ? cnt : 0) - (pop ? 1 : 0);
    end
    if (offer && !fl && !acc) begin
      m_ovf   = 1'b1;
      m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
    end else if (clr) begin
      m_ovf = 1'b0; m_drops = 0;
    end
    @(posedge clk);
    #1;
    check_state("post");
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; tm_count = 2'd0; rd_req = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    do_reset(1'b0);
    check("reset.wr_en",    32'(wr_en),    32'd0);
    check("reset.rd_valid", 32'(rd_valid), 32'd0);

    // Fill with groups of three, then the sixth group no longer fits.
    repeat (5) step(1, 3, 0, 0, 0);
    check("p1.fifocount", 32'(fifocount), 32'd15);
    check("p1.free2",     32'(free2),     32'd0);
    check("p1.free3",     32'(free3),     32'd0);
    step(1, 3, 0, 0, 0);
    check("p1.overflow",   32'(overflow),   32'd1);
    check("p1.drop_count", 32'(drop_count), 32'd1);
    check("p1.wp",         32'(wr_addr0),   32'd15);

    // Same-cycle pop does not make room for the group.
    step(0, 0, 1, 0, 0);
    step(1, 3, 1, 0, 0);
    check("p2.wr_en",     32'(c_wr_en),    32'd0);
    check("p2.rd_valid",  32'(c_rd_valid), 32'd1);
    check("p2.fifocount", 32'(fifocount),  32'd13);
    check("p2.overflow",  32'(overflow),   32'd1);

    // Lane addresses wrap around the end of the buffer.
    step(0, 0, 0, 1, 0);
    repeat (4) step(1, 3, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    step(1, 3, 0, 0, 0);
    check("p3.addr0", 32'(c_a0),    32'd14);
    check("p3.addr1", 32'(c_a1),    32'd15);
    check("p3.addr2", 32'(c_a2),    32'd0);
    check("p3.wr_en", 32'(c_wr_en), 32'd7);
    check("p3.wp",    32'(wr_addr0), 32'd1);

    // Write and pop together.
    step(0, 0, 0, 1, 0);
    repeat (2) step(1, 3, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    step(1, 2, 1, 0, 0);
    check("p4.rd_valid",  32'(c_rd_valid), 32'd1);
    check("p4.rd_addr",   32'(c_rd_addr),  32'd2);
    check("p4.rp",        32'(rd_addr),    32'd3);
    check("p4.fifocount", 32'(fifocount),  32'd5);

    // Flush beats admit and pop, keeps the overflow state.
    step(1, 3, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 3, 1, 1, 0);
    check("p5.wr_en",      32'(c_wr_en),    32'd0);
    check("p5.rd_valid",   32'(c_rd_valid), 32'd0);
    check("p5.fifocount",  32'(fifocount),  32'd0);
    check("p5.empty",      32'(empty),      32'd1);
    check("p5.overflow",   32'(overflow),   32'd1);
    check("p5.drop_count", 32'(drop_count), 32'd2);

    // Disabled offers are neither written nor dropped.
    step(0, 3, 0, 0, 0);
    check("en0.fifocount", 32'(fifocount), 32'd0);

    // Saturating drop counter and clear interactions.
    repeat (5) step(1, 3, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("p6.full", 32'(full), 32'd1);
    repeat (260) step(1, 1, 0, 0, 0);
    check("p6.sat", 32'(drop_count), 32'd255);
    step(1, 1, 0, 0, 1);
    check("p6.clrdrop.ovf", 32'(overflow),   32'd1);
    check("p6.clrdrop.cnt", 32'(drop_count), 32'd1);
    step(0, 0, 0, 0, 1);
    check("p6.clr.ovf", 32'(overflow),   32'd0);
    check("p6.clr.cnt", 32'(drop_count), 32'd0);

    // Pops continue while capture is disabled.
    step(0, 3, 1, 0, 0);
    check("en0.pop", 32'(fifocount), 32'd15);

    // Reset overrides simultaneous flush, clear and traffic.
    step(1, 3, 0, 0, 0);
    do_reset(1'b1);

    for (int n = 0; n < 800; n++) begin
      step($urandom_range(99) < 85,
           int'($urandom_range(3)),
           $urandom_range(99) < ((n / 100) % 2 == 0 ? 30 : 70),
           $urandom_range(99) < 3,
           $urandom_range(99) < 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios2_oci_fifo_ctrl.md
Name: nios2_oci_fifo_ctrl

Overview:
Pointer, occupancy and admission controller for the OCI trace FIFO, which is a DEPTH-entry circular buffer. The trace packer offers 0-3 words per cycle on tm_count. This block decides whether the whole group is admitted, generates up to three write lanes with their addresses, and sequences one-word-per-cycle reads toward the trace output port. The storage RAM is external; this block owns only the control state and the status flags (empty, full, free2, free3, overflow).

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of 2 and at least 4.
PTR_W, 4, pointer width; equals log2(DEPTH).
DROP_W, 8, width of the saturating dropped-group counter.

Ports:
clk  in  1  the single clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  trace capture enable; when 0, tm_count is ignored.
tm_count  in  2  number of trace words offered this cycle (0-3).
rd_req  in  1  consumer requests one word this cycle.
flush  in  1  synchronous FIFO flush.
ovf_clr  in  1  clears overflow and drop_count.
wr_en  out  3  per-lane write strobe; lane i writes RAM[wr_addr_i].
wr_addr0  out  PTR_W  lane 0 write address, equal to wp.
wr_addr1  out  PTR_W  lane 1 write address, equal to (wp+1) mod DEPTH.
wr_addr2  out  PTR_W  lane 2 write address, equal to (wp+2) mod DEPTH.
rd_addr  out  PTR_W  read address, equal to rp.
rd_valid  out  1  a pop occurs this cycle.
fifocount  out  PTR_W+1  registered occupancy, 0..DEPTH.
empty  out  1  fifocount==0.
full  out  1  fifocount==DEPTH.
free2  out  1  fifocount<=DEPTH-2.
free3  out  1  fifocount<=DEPTH-3.
overflow  out  1  sticky flag: at least one group was dropped.
drop_count  out  DROP_W  saturating count of dropped groups.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - wp=0, rp=0, fifocount=0, overflow=0, drop_count=0.
  - Hence empty=1, full=0, free2=1, free3=1, wr_en=0, rd_valid=0.
- Free space: free = DEPTH - fifocount, taken from the registered count.
  - A pop in the same cycle does NOT add to free space. Admission is deliberately conservative.
- Admission (combinational, same cycle):
  - offer = enable && tm_count!=0.
  - accept = offer && tm_count<=free.
  - Admission is all-or-nothing; a group is never partially written.
- Write lanes: wr_en[i] = accept && i<tm_count. Lane addresses wrap modulo DEPTH.
- Pop: pop = rd_req && !empty; rd_valid = pop. The consumer samples RAM[rd_addr] this cycle.
- Next-state updates, applied at the edge (outputs registered, latency 1 cycle):
  - wp += accept ? tm_count : 0, modulo DEPTH.
  - rp += pop, modulo DEPTH.
  - fifocount += (accept ? tm_count : 0) - pop.
  - Simultaneous admit and pop are both applied. fifocount stays within 0..DEPTH by construction.
- Drop: when offer && !accept:
  - overflow is set to 1.
  - drop_count increments, saturating at all-ones.
  - No write occurs and the pointers are unchanged by the write side.
- Flush has priority over admit and pop in the same cycle:
  - wp=rp=0 and fifocount=0.
  - wr_en=0 and rd_valid=0 are forced during the flush cycle.
  - An offer made during flush is neither admitted nor counted as dropped.
  - overflow and drop_count are preserved.
- ovf_clr:
  - Clears overflow and drop_count next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_count=1.
- Reset has priority over flush and ovf_clr.
- Status flags (empty, full, free2, free3) are decoded from the registered fifocount only.
- Invariant: fifocount == (wp - rp) mod DEPTH, except at fifocount==DEPTH, where wp==rp and full=1.
- enable=0 suppresses admission and drops; pops continue normally.

Decomposition:
- Shared package nios2_oci_trace_pkg holds:
  - DEPTH/PTR_W defaults.
  - The tm_count width constant.
  - A function computing the lane address (base + i) mod DEPTH.
- One sub-module is natural: nios2_oci_fifo_status. It is pure combinational decode of fifocount into empty/full/free2/free3/free.
- Pointer, count and drop logic stay in the top module.

Test Plan:
1. Reset, then tm_count=3 for 5 cycles with rd_req=0 -> wr_en=3'b111 on cycles 1-5, fifocount=15, free2=0 and free3=0 after the 5th accept; a 6th offer of 3 is dropped: overflow=1, drop_count=1, wp=15.
2. Fill to fifocount=14, offer tm_count=3 together with rd_req=1 -> offer dropped (conservative check); pop occurs; fifocount=13, overflow=1.
3. wp=14, offer tm_count=3 -> wr_addr0=14, wr_addr1=15, wr_addr2=0, wr_en=3'b111, wp=1 next cycle.
4. fifocount=4, tm_count=2 with rd_req=1 -> fifocount=5, rd_valid=1, rd_addr=old rp, rp incremented by 1.
5. fifocount=9 with flush=1, tm_count=3, rd_req=1 -> wr_en=0, rd_valid=0; next cycle fifocount=0, wp=rp=0, empty=1, overflow unchanged.
6. drop_count=255 plus another drop -> stays 255. Drop together with ovf_clr in the same cycle -> overflow=1, drop_count=1. ovf_clr alone -> both 0.
